tape_memory: RTL and testbench
==============================

# tape_memory

Tape side of the universal Turing machine: holds the tape contents and head position, presents the symbol under the head (s2..s0) to the transition logic, and accepts the transition logic's written symbol (z2..z0) plus head move. It closes the loop opposite the new-symbol/next-state/direction logic: that logic consumes `cur_sym` and produces `new_sym`, and this block stores `new_sym` and produces the next `cur_sym`. It also provides a load port so the tape can be programmed before a run.

## Interface
- `TAPE_LEN`, default 16: number of tape cells; must be a power of two, at least 4.
- `SYM_W`, default 3: symbol width; bit 2 is s2/z2, bit 0 is s0/z0.
- `ADDR_W`, default 4: log2(`TAPE_LEN`).
- `START_HEAD`, default 0: head position after reset.

- `clk`, input, 1: single clock; all state changes on its rising edge.
- `reset`, input, 1: synchronous, active-high.
- `load_en`, input, 1: write `load_sym` into cell `load_addr`; honoured only in LOAD.
- `load_addr`, input, ADDR_W: target cell for `load_en`.
- `load_sym`, input, SYM_W: symbol to load.
- `start`, input, 1: single-cycle pulse; leaves LOAD and begins the run.
- `cur_sym`, output, SYM_W: symbol under the head; valid only when `sym_valid` is high.
- `sym_valid`, output, 1: `cur_sym` is stable and a step may be accepted.
- `step_valid`, input, 1: `new_sym` and `move_right` are valid.
- `new_sym`, input, SYM_W: symbol to write at the head.
- `move_right`, input, 1: 1 moves the head to +1; 0 moves it to −1.
- `halt_req`, input, 1: stop the machine; no write is performed.
- `head`, output, ADDR_W: current head position.
- `halted`, output, 1: sticky; high in HALT.
- `fault`, output, 1: sticky; high when a move left the tape bounds.

## Operation
- States and their outputs:
  - LOAD: entered from reset.
  - FETCH: one cycle; registers `tape[head]` into `cur_sym`.
  - PRESENT: `sym_valid`=1.
  - HALT: `halted`=1.
  - FAULT: `fault`=1.
- Reset sets every cell to 0 (the blank symbol), `head`=`START_HEAD`, `cur_sym`=0, state=LOAD, and all flags to 0.
- LOAD:
  - When `load_en` is high, write `tape[load_addr]` <= `load_sym`.
  - On `start`, go to FETCH. If `start` and `load_en` arrive in the same cycle, the load is performed first and FETCH sees the loaded value.
- PRESENT:
  - Handshake completes on `sym_valid` && `step_valid`.
  - On completion: write `tape[head]` <= `new_sym` and set `head` <= `head` ± 1, then go to FETCH.
  - `step_valid` outside PRESENT is ignored.
- Bounds: a move right at `head`=`TAPE_LEN`−1, or a move left at `head`=0, is a fault.
  - The write still happens.
  - `head` does not change; it does not wrap.
  - State goes to FAULT.
- `halt_req`:
  - In PRESENT it has priority over `step_valid`: no write, no move, go to HALT.
  - In FETCH it is acted on in the following PRESENT cycle.
  - In LOAD it is ignored.
- HALT and FAULT are absorbing until `reset`.
- `load_en` outside LOAD is ignored, so the tape is never modified by the load port mid-run.

## Timing
- Latency from step acceptance to the next `sym_valid`: 2 cycles (edge 1 writes and moves, edge 2 registers `cur_sym` in FETCH).
- If the head returns to a cell written earlier, FETCH reads that written value; no bypass is needed because the write completes before FETCH.
- `cur_sym`, `head`, `sym_valid`, `halted` and `fault` are all registered; there is no combinational path from input to output.
- Maximum throughput: one step per 2 cycles.
- Reset asserted in any state, including the write cycle of PRESENT, restores reset values on the next edge; no partial write survives.

## Structure
- Shared UTM package holds:
  - symbol width and the blank-symbol constant (0);
  - the state enum LOAD/FETCH/PRESENT/HALT/FAULT;
  - the direction encoding (1=right).
- One natural sub-module, `tape_cell_array`: a register array with one synchronous write port, one read port, and a synchronous clear on `reset`. The FSM and head counter stay in the top module.

## Test plan
- Reset, then `start` with no loads → `head`=0, `cur_sym`=0, `sym_valid` high 2 cycles after `start`.
- Load cells 0..3 = 5,1,6,2, then `start` → `cur_sym`=5. Step (`new_sym`=7, right) → `head`=1, `cur_sym`=1. Step (`new_sym`=3, left) → `head`=0, `cur_sym`=7.
- `START_HEAD`=15, step right with `new_sym`=4 → `fault`=1, `head` stays 15, cell 15 = 4, `sym_valid`=0 thereafter; further `step_valid` has no effect.
- In PRESENT, assert `halt_req` and `step_valid` together → `halted`=1, tape and `head` unchanged; verify the cell under the head by reset-free readback through `cur_sym`.
- Assert `reset` on the same cycle as an accepted step → all cells 0, `head`=`START_HEAD`, state LOAD; `load_en` with `start` in the same cycle (addr 0, sym 6) → first `cur_sym`=6.
- `load_en` pulsed during PRESENT → tape unchanged.

Source files
------------

// File: rtl/tape_memory_pkg.sv
// Shared UTM definitions used by the tape side of the machine.
//   - symbol width default and the blank symbol
//   - FSM state enum for the tape controller
//   - head direction encoding
package tape_memory_pkg;

  localparam int SYM_W_DEF = 3;

  // The blank symbol; every cell holds it after reset.
  localparam logic [SYM_W_DEF-1:0] BLANK_SYM = '0;

  // Head move direction as carried on move_right.
  localparam logic DIR_RIGHT = 1'b1;
  localparam logic DIR_LEFT  = 1'b0;

  typedef enum logic [2:0] {
    ST_LOAD    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_PRESENT = 3'd2,
    ST_HALT    = 3'd3,
    ST_FAULT   = 3'd4
  } tape_state_e;

endpackage

// File: rtl/tape_cell_array.sv
// Tape storage: TAPE_LEN cells of SYM_W bits.
//   clk, reset : clock and synchronous active-high clear (all cells -> blank)
//   we, waddr, wdata : single synchronous write port
//   raddr, rdata     : asynchronous read port (registered by the caller)
module tape_cell_array
  import tape_memory_pkg::*;
#(
  parameter int TAPE_LEN = 16,
  parameter int SYM_W    = 3,
  parameter int ADDR_W   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [SYM_W-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [SYM_W-1:0]  rdata
);

  logic [SYM_W-1:0] cells [TAPE_LEN];

  // Reset wins over a same-cycle write so no partial write survives.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < TAPE_LEN; i++) cells[i] <= SYM_W'(BLANK_SYM);
    end else if (we) begin
      cells[waddr] <= wdata;
    end
  end

  assign rdata = cells[raddr];

endmodule

// File: rtl/tape_memory.sv
// Tape side of the universal Turing machine. Holds tape and head, presents
// the symbol under the head, and accepts the written symbol plus head move.
//   clk, reset                  : clock, synchronous active-high reset
//   load_en, load_addr, load_sym: tape programming, honoured only in LOAD
//   start                       : pulse; leave LOAD and begin the run
//   cur_sym, sym_valid          : symbol under the head and its valid flag
//   step_valid, new_sym, move_right : step from the transition logic
//   halt_req                    : stop the machine without writing
//   head, halted, fault         : head position and sticky status flags
//   state                       : FSM state, for observation
//
// Handshake: a step is accepted on a rising edge where sym_valid and
// step_valid are both high and no halt is pending; halt takes priority.
// sym_valid is only ever high in PRESENT, so step_valid elsewhere is ignored.
module tape_memory
  import tape_memory_pkg::*;
#(
  parameter int                TAPE_LEN   = 16,
  parameter int                SYM_W      = 3,
  parameter int                ADDR_W     = 4,
  parameter logic [ADDR_W-1:0] START_HEAD = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [SYM_W-1:0]  load_sym,
  input  logic              start,
  output logic [SYM_W-1:0]  cur_sym,
  output logic              sym_valid,
  input  logic              step_valid,
  input  logic [SYM_W-1:0]  new_sym,
  input  logic              move_right,
  input  logic              halt_req,
  output logic [ADDR_W-1:0] head,
  output logic              halted,
  output logic              fault,
  output tape_state_e       state
);

  localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(TAPE_LEN - 1);

  logic              halt_pend;  // halt_req seen during FETCH
  logic              halt_now;
  logic              load_wr;
  logic              step_acc;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [SYM_W-1:0]  wdata;
  logic [SYM_W-1:0]  rdata;
  logic              out_of_bounds;

  assign halt_now = halt_req || halt_pend;
  assign load_wr  = (state == ST_LOAD) && load_en;
  assign step_acc = (state == ST_PRESENT) && step_valid && !halt_now;
  assign we       = load_wr || step_acc;
  assign waddr    = load_wr ? load_addr : head;
  assign wdata    = load_wr ? load_sym  : new_sym;

  assign out_of_bounds = (move_right == DIR_RIGHT) ? (head == LAST_CELL)
                                                   : (head == '0);

  tape_cell_array #(
    .TAPE_LEN (TAPE_LEN),
    .SYM_W    (SYM_W),
    .ADDR_W   (ADDR_W)
  ) u_cells (
    .clk   (clk),
    .reset (reset),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .raddr (head),
    .rdata (rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_LOAD;
      head      <= START_HEAD;
      cur_sym   <= '0;
      sym_valid <= 1'b0;
      halted    <= 1'b0;
      fault     <= 1'b0;
      halt_pend <= 1'b0;
    end else begin
      case (state)
        ST_LOAD: begin
          // A same-cycle load lands in the array this edge, before FETCH reads.
          if (start) state <= ST_FETCH;
        end
        ST_FETCH: begin
          cur_sym   <= rdata;
          sym_valid <= 1'b1;
          halt_pend <= halt_req;
          state     <= ST_PRESENT;
        end
        ST_PRESENT: begin
          if (halt_now) begin
            sym_valid <= 1'b0;
            halted    <= 1'b1;
            halt_pend <= 1'b0;
            state     <= ST_HALT;
          end else if (step_valid) begin
            sym_valid <= 1'b0;
            if (out_of_bounds) begin
              // Write still happens; head stays put instead of wrapping.
              fault <= 1'b1;
              state <= ST_FAULT;
            end else begin
              head  <= (move_right == DIR_RIGHT) ? head + ADDR_W'(1)
                                                 : head - ADDR_W'(1);
              state <= ST_FETCH;
            end
          end
        end
        ST_HALT:  state <= ST_HALT;
        ST_FAULT: state <= ST_FAULT;
        default:  state <= ST_LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_tape_memory.sv
module tb_tape_memory;
  import tape_memory_pkg::*;

  localparam int SYM_W  = 3;
  localparam int ADDR_W = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset;
  logic              load_en;
  logic [ADDR_W-1:0] load_addr;
  logic [SYM_W-1:0]  load_sym;
  logic              start;
  logic              step_valid;
  logic [SYM_W-1:0]  new_sym;
  logic              move_right;
  logic              halt_req;

  logic [SYM_W-1:0]  cur_sym_a, cur_sym_b;
  logic              sym_valid_a, sym_valid_b;
  logic [ADDR_W-1:0] head_a, head_b;
  logic              halted_a, halted_b;
  logic              fault_a, fault_b;
  tape_state_e       state_a, state_b;

  // Instance A: head starts at cell 0. Instance B: head starts at cell 15.
  tape_memory #(.TAPE_LEN(16), .SYM_W(SYM_W), .ADDR_W(ADDR_W), .START_HEAD(4'd0)) dut_a (
    .clk(clk), .reset(reset), .load_en(load_en), .load_addr(load_addr),
    .load_sym(load_sym), .start(start), .cur_sym(cur_sym_a), .sym_valid(sym_valid_a),
    .step_valid(step_valid), .new_sym(new_sym), .move_right(move_right),
    .halt_req(halt_req), .head(head_a), .halted(halted_a), .fault(fault_a),
    .state(state_a)
  );

  tape_memory #(.TAPE_LEN(16), .SYM_W(SYM_W), .ADDR_W(ADDR_W), .START_HEAD(4'd15)) dut_b (
    .clk(clk), .reset(reset), .load_en(load_en), .load_addr(load_addr),
    .load_sym(load_sym), .start(start), .cur_sym(cur_sym_b), .sym_valid(sym_valid_b),
    .step_valid(step_valid), .new_sym(new_sym), .move_right(move_right),
    .halt_req(halt_req), .head(head_b), .halted(halted_b), .fault(fault_b),
    .state(state_b)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    load_en = 1'b0; load_addr = '0; load_sym = '0; start = 1'b0;
    step_valid = 1'b0; new_sym = '0; move_right = 1'b0; halt_req = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic load_cell(input logic [ADDR_W-1:0] a, input logic [SYM_W-1:0] s);
    load_en = 1'b1; load_addr = a; load_sym = s;
    tick();
    load_en = 1'b0;
  endtask

  task automatic start_run();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
  endtask

  // Issues one accepted step and waits through FETCH (2 edges).
  task automatic do_step(input logic [SYM_W-1:0] s, input logic dir);
    step_valid = 1'b1; new_sym = s; move_right = dir;
    tick();
    step_valid = 1'b0;
    tick();
  endtask

  // ---------------- stimulus + checks ----------------
  initial begin
    reset = 1'b1;
    idle_inputs();

    // Reset values
    do_reset();
    check_eq("rst_head_a", 32'(head_a), 32'd0);
    check_eq("rst_head_b", 32'(head_b), 32'd15);
    check_eq("rst_cur_sym", 32'(cur_sym_a), 32'd0);
    check_eq("rst_sym_valid", 32'(sym_valid_a), 32'd0);
    check_eq("rst_flags", 32'({halted_a, fault_a}), 32'd0);
    check_eq("rst_state", 32'(state_a), 32'(ST_LOAD));

    // Start with no loads: sym_valid two cycles after start
    start = 1'b1;
    tick();
    start = 1'b0;
    check_eq("t1_valid_early", 32'(sym_valid_a), 32'd0);
    tick();
    check_eq("t1_valid", 32'(sym_valid_a), 32'd1);
    check_eq("t1_cur_sym", 32'(cur_sym_a), 32'd0);
    check_eq("t1_head", 32'(head_a), 32'd0);

    // Loaded tape, two steps, return to written cell
    do_reset();
    exp_q = '{32'd5, 32'd1, 32'd6, 32'd2};
    for (int i = 0; i < 4; i++) load_cell(ADDR_W'(i), SYM_W'(exp_q[i]));
    start_run();
    check_eq("t2_cur_sym0", 32'(cur_sym_a), exp_q[0]);
    step_valid = 1'b1; new_sym = 3'd7; move_right = 1'b1;
    tick();
    step_valid = 1'b0;
    check_eq("t2_valid_gap", 32'(sym_valid_a), 32'd0);
    check_eq("t2_head1", 32'(head_a), 32'd1);
    tick();
    check_eq("t2_cur_sym1", 32'(cur_sym_a), exp_q[1]);
    check_eq("t2_valid1", 32'(sym_valid_a), 32'd1);
    do_step(3'd3, 1'b0);
    check_eq("t2_head0", 32'(head_a), 32'd0);
    check_eq("t2_cur_sym_back", 32'(cur_sym_a), 32'd7);
    // Left move off cell 0: write happens, head holds, fault
    step_valid = 1'b1; new_sym = 3'd2; move_right = 1'b0;
    tick();
    step_valid = 1'b0;
    check_eq("t2_lfault", 32'(fault_a), 32'd1);
    check_eq("t2_lfault_head", 32'(head_a), 32'd0);
    check_eq("t2_lfault_cell", 32'(dut_a.u_cells.cells[0]), 32'd2);

    // Right move off the last cell (instance B)
    do_reset();
    start_run();
    check_eq("t3_valid", 32'(sym_valid_b), 32'd1);
    step_valid = 1'b1; new_sym = 3'd4; move_right = 1'b1;
    tick();
    step_valid = 1'b0;
    check_eq("t3_fault", 32'(fault_b), 32'd1);
    check_eq("t3_head", 32'(head_b), 32'd15);
    check_eq("t3_cell15", 32'(dut_b.u_cells.cells[15]), 32'd4);
    check_eq("t3_valid_off", 32'(sym_valid_b), 32'd0);
    step_valid = 1'b1; new_sym = 3'd1; move_right = 1'b0;
    tick();
    tick();
    step_valid = 1'b0;
    check_eq("t3_cell15_hold", 32'(dut_b.u_cells.cells[15]), 32'd4);
    check_eq("t3_head_hold", 32'(head_b), 32'd15);
    check_eq("t3_state", 32'(state_b), 32'(ST_FAULT));
    check_eq("t3_fault_sticky", 32'(fault_b), 32'd1);

    // Halt has priority over a step
    do_reset();
    load_cell(4'd0, 3'd5);
    start_run();
    halt_req = 1'b1; step_valid = 1'b1; new_sym = 3'd7; move_right = 1'b1;
    tick();
    halt_req = 1'b0; step_valid = 1'b0;
    check_eq("t4_halted", 32'(halted_a), 32'd1);
    check_eq("t4_head", 32'(head_a), 32'd0);
    check_eq("t4_cell0", 32'(dut_a.u_cells.cells[0]), 32'd5);
    check_eq("t4_cur_sym", 32'(cur_sym_a), 32'd5);
    check_eq("t4_valid", 32'(sym_valid_a), 32'd0);
    tick();
    check_eq("t4_state", 32'(state_a), 32'(ST_HALT));

    // Reset on the same edge as an accepted step
    do_reset();
    load_cell(4'd0, 3'd5);
    load_cell(4'd1, 3'd1);
    start_run();
    step_valid = 1'b1; new_sym = 3'd7; move_right = 1'b1; reset = 1'b1;
    tick();
    reset = 1'b0; step_valid = 1'b0;
    check_eq("t5_cell0", 32'(dut_a.u_cells.cells[0]), 32'd0);
    check_eq("t5_cell1", 32'(dut_a.u_cells.cells[1]), 32'd0);
    check_eq("t5_head", 32'(head_a), 32'd0);
    check_eq("t5_state", 32'(state_a), 32'(ST_LOAD));
    // Load and start together: FETCH sees the loaded value
    load_en = 1'b1; load_addr = 4'd0; load_sym = 3'd6; start = 1'b1;
    tick();
    load_en = 1'b0; start = 1'b0;
    tick();
    check_eq("t5_cur_sym", 32'(cur_sym_a), 32'd6);
    check_eq("t5_valid", 32'(sym_valid_a), 32'd1);

    // load_en in PRESENT is ignored
    load_cell(4'd0, 3'd3);
    load_cell(4'd1, 3'd2);
    check_eq("t6_cell0", 32'(dut_a.u_cells.cells[0]), 32'd6);
    check_eq("t6_cell1", 32'(dut_a.u_cells.cells[1]), 32'd0);
    check_eq("t6_valid", 32'(sym_valid_a), 32'd1);
    do_step(3'd1, 1'b1);
    check_eq("t6_head", 32'(head_a), 32'd1);
    check_eq("t6_cur_sym", 32'(cur_sym_a), 32'd0);

    // Halt pulse during FETCH takes effect in the next PRESENT cycle
    step_valid = 1'b1; new_sym = 3'd2; move_right = 1'b1;
    tick();
    step_valid = 1'b0; halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    check_eq("t7_valid", 32'(sym_valid_a), 32'd1);
    tick();
    check_eq("t7_halted", 32'(halted_a), 32'd1);
    check_eq("t7_head", 32'(head_a), 32'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
